// File: rtl/shiftreg_multi_if.sv
// Bus bundle for shiftreg_multi: control, data in/out and fill status.
// Carries the rot input only when SHIFTREG_ROTATE_EN is defined.
interface shiftreg_multi_if #(
    parameter int W    = 1,
    parameter int N    = 1,
    parameter int LENW = 8
);
    logic            step;
    logic            load;
    logic [LENW-1:0] len;
    logic [W-1:0]    in;
    logic [W*N-1:0]  pin;
    logic [W-1:0]    out;
    logic [W*N-1:0]  pout;
    logic [LENW-1:0] count;
    logic            full;
`ifdef SHIFTREG_ROTATE_EN
    logic            rot;

    modport master (
        output step, load, len, in, pin, rot,
        input  out, pout, count, full
    );
    modport slave (
        input  step, load, len, in, pin, rot,
        output out, pout, count, full
    );
`else
    modport master (
        output step, load, len, in, pin,
        input  out, pout, count, full
    );
    modport slave (
        input  step, load, len, in, pin,
        output out, pout, count, full
    );
`endif
endinterface

// File: rtl/shiftreg_multi.sv
// Multi-lane shift register, runtime depth, parallel load, fill counter.
// Optional circular mode enabled by defining SHIFTREG_ROTATE_EN.
module shiftreg_multi #(
    parameter int W    = 1,
    parameter int N    = 1,
    parameter int LENW = 8
) (
    input logic           clk,
    input logic           clr,
    shiftreg_multi_if.slave bus
);
    localparam logic [LENW-1:0] NMAX = LENW'(N);
    localparam logic [LENW-1:0] ONE  = LENW'(1);

    logic [N-1:0][W-1:0] stg_q, stg_d;
    logic [LENW-1:0]     cnt_q, cnt_d;
    logic [LENW-1:0]     eff_len;
    logic [W-1:0]        tap;
    logic [W-1:0]        feed;
    logic                rot_w;

    always_comb begin
        if (bus.len == '0)
            eff_len = ONE;
        else if (bus.len > NMAX)
            eff_len = NMAX;
        else
            eff_len = bus.len;
    end

    // Output tap follows len immediately; stored data is untouched.
    always_comb begin
        tap = '0;
        for (int k = 0; k < N; k++) begin
            if (LENW'(k) == eff_len - ONE)
                tap = stg_q[k];
        end
    end

`ifdef SHIFTREG_ROTATE_EN
    assign rot_w = bus.rot;
`else
    assign rot_w = 1'b0;
`endif

    assign feed = rot_w ? tap : bus.in;

    always_comb begin
        stg_d = stg_q;
        cnt_d = cnt_q;
        if (bus.load) begin
            stg_d = bus.pin;
            cnt_d = eff_len;
        end else if (bus.step) begin
            for (int k = N - 1; k > 0; k--)
                stg_d[k] = stg_q[k-1];
            stg_d[0] = feed;
            if (!rot_w)
                cnt_d = (cnt_q >= eff_len) ? eff_len : cnt_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            stg_q <= '0;
            cnt_q <= '0;
        end else begin
            stg_q <= stg_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.out   = tap;
    assign bus.pout  = stg_q;
    assign bus.count = cnt_q;
    assign bus.full  = (cnt_q >= eff_len);

endmodule

// File: tb/tb_shiftreg_multi.sv
// Bench for shiftreg_multi (W=4, N=8): queue model plus directed checks.
// Rotation stimulus is included when SHIFTREG_ROTATE_EN is defined.
module tb_shiftreg_multi;
    localparam int W    = 4;
    localparam int N    = 8;
    localparam int LENW = 8;

    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;

    shiftreg_multi_if #(.W(W), .N(N), .LENW(LENW)) bus ();

    shiftreg_multi #(.W(W), .N(N), .LENW(LENW)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    int nchk = 0;
    int nerr = 0;
    bit mon_en = 1'b0;

    logic [W-1:0] mq[$];
    int           mcnt = 0;

    function automatic int effl(input int l);
        if (l < 1) return 1;
        if (l > N) return N;
        return l;
    endfunction

    function automatic logic [W*N-1:0] mpout();
        logic [W*N-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = mq[k];
        return r;
    endfunction

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        nchk++;
        if (a !== e) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Model: stages as a queue, stage 0 at the front.
    always @(posedge clk) begin
        int e;
        bit r;
        logic [W-1:0] f;
        e = effl(int'(bus.len));
        r = 1'b0;
`ifdef SHIFTREG_ROTATE_EN
        r = bus.rot;
`endif
        if (clr) begin
            mq = {};
            repeat (N) mq.push_back('0);
            mcnt = 0;
        end else if (bus.load) begin
            for (int k = 0; k < N; k++) mq[k] = bus.pin[k*W +: W];
            mcnt = e;
        end else if (bus.step) begin
            f = r ? mq[e-1] : bus.in;
            mq.push_front(f);
            void'(mq.pop_back());
            if (!r) mcnt = (mcnt + 1 > e) ? e : mcnt + 1;
        end
    end

    always @(negedge clk) begin
        int e;
        if (mon_en) begin
            e = effl(int'(bus.len));
            chk("m_out", 64'(bus.out), 64'(mq[e-1]));
            chk("m_pout", 64'(bus.pout), 64'(mpout()));
            chk("m_count", 64'(bus.count), 64'(mcnt));
            chk("m_full", 64'(bus.full), 64'(mcnt >= e));
        end
    end

    initial begin
        bus.step = 1'b1;
        bus.load = 1'b0;
        bus.len  = 8'd5;
        bus.in   = 4'hF;
        bus.pin  = '0;
`ifdef SHIFTREG_ROTATE_EN
        bus.rot  = 1'b0;
`endif
        clr = 1'b1;
        tick();
        tick();
        chk("rst_out", 64'(bus.out), 64'h0);
        chk("rst_pout", 64'(bus.pout), 64'h0);
        chk("rst_count", 64'(bus.count), 64'h0);
        chk("rst_full", 64'(bus.full), 64'h0);
        mon_en = 1'b1;

        // Fill with one marked bit at len=5
        clr = 1'b0;
        bus.in = 4'hA;
        tick();
        chk("fill_cnt1", 64'(bus.count), 64'd1);
        bus.in = 4'h0;
        for (int i = 2; i <= 5; i++) begin
            if (i == 5) begin
                tick();
                chk("fill_out5", 64'(bus.out), 64'hA);
                chk("fill_full5", 64'(bus.full), 64'h1);
            end else begin
                tick();
                chk("fill_out_early", 64'(bus.out), 64'h0);
                chk("fill_full_early", 64'(bus.full), 64'h0);
            end
            chk("fill_cnt", 64'(bus.count), 64'(i));
        end
        tick();
        chk("fill_hold_cnt", 64'(bus.count), 64'd5);
        chk("fill_out6", 64'(bus.out), 64'h0);

        // Load wins over step
        bus.pin  = 32'hCBA39876;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        bus.step = 1'b0;
        chk("ld_out", 64'(bus.out), 64'h3);
        chk("ld_cnt", 64'(bus.count), 64'd5);
        chk("ld_pout", 64'(bus.pout), 64'hCBA39876);

        // Length clamp
        bus.len = 8'd0;
        #1 chk("len0_out", 64'(bus.out), 64'h6);
        bus.len = 8'd200;
        #1 chk("len200_out", 64'(bus.out), 64'hC);
        bus.len = 8'd8;
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        chk("len8_cnt", 64'(bus.count), 64'd6);
        chk("len8_full", 64'(bus.full), 64'h0);
        bus.len = 8'd2;
        #1;
        chk("len2_full", 64'(bus.full), 64'h1);
        chk("len2_cnt", 64'(bus.count), 64'd6);
        chk("len2_out", 64'(bus.out), 64'h6);
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        chk("len2_resat", 64'(bus.count), 64'd2);

        // Clear in the middle of a fill
        clr = 1'b1;
        tick();
        clr = 1'b0;
        bus.len = 8'd5;
        bus.in = 4'hF;
        bus.step = 1'b1;
        repeat (3) tick();
        chk("mid_cnt3", 64'(bus.count), 64'd3);
        bus.step = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("mid_cnt0", 64'(bus.count), 64'd0);
        chk("mid_pout0", 64'(bus.pout), 64'h0);
        bus.in = 4'h0;
        bus.step = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_out", 64'(bus.out), 64'h0);
        end
        chk("mid_cnt5", 64'(bus.count), 64'd5);
        chk("mid_full", 64'(bus.full), 64'h1);

`ifdef SHIFTREG_ROTATE_EN
        // Circular buffer of length 4
        bus.pin = 32'h87654321;
        bus.len = 8'd4;
        bus.load = 1'b1;
        bus.step = 1'b0;
        tick();
        bus.load = 1'b0;
        bus.rot = 1'b1;
        bus.step = 1'b1;
        tick();
        chk("rot_1", 64'(bus.pout[15:0]), 64'h3214);
        repeat (3) tick();
        chk("rot_pout", 64'(bus.pout[15:0]), 64'h4321);
        chk("rot_cnt", 64'(bus.count), 64'd4);
        bus.rot = 1'b0;
        bus.step = 1'b0;
`endif

        // Mixed traffic checked by the model only
        for (int i = 0; i < 40; i++) begin
            bus.len  = 8'($urandom_range(0, 10));
            bus.load = ($urandom_range(0, 7) == 0);
            bus.step = ($urandom_range(0, 3) != 0);
            bus.in   = 4'($urandom);
            bus.pin  = 32'($urandom);
`ifdef SHIFTREG_ROTATE_EN
            bus.rot  = ($urandom_range(0, 3) == 0);
`endif
            tick();
        end
        bus.step = 1'b0;
        bus.load = 1'b0;
        tick();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
